// File: rtl/nios2_oci_dct_pkg.sv
// Shared types and helpers for the OCI debug compact-trace unpacker.
// Holds the unpacker state encoding and the pointer-width helper.
package nios2_oci_dct_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        UNPACK = 2'd1,
        DRAIN  = 2'd2,
        ENDED  = 2'd3
    } dct_state_e;

    // Ceiling log2 usable in constant expressions (value >= 1).
    function automatic int dct_clog2(input int value);
        int result;
        result = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                result = i + 1;
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/nios2_oci_dct_fifo.sv
// First-word-fall-through FIFO of SLOT_W x FIFO_DEPTH trace slots.
// Head data reads as zero whenever the FIFO is empty.
module nios2_oci_dct_fifo
    import nios2_oci_dct_pkg::*;
#(
    parameter int SLOT_W     = 2,
    parameter int FIFO_DEPTH = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_push,
    input  logic [SLOT_W-1:0] i_data,
    input  logic              i_pop,
    output logic [SLOT_W-1:0] o_data,
    output logic              o_full,
    output logic              o_empty
);

    localparam int AW = dct_clog2(FIFO_DEPTH);

    logic [SLOT_W-1:0] r_mem [FIFO_DEPTH];
    logic [AW:0]       r_wr_ptr;
    logic [AW:0]       r_rd_ptr;

    logic w_empty;
    logic w_full;
    logic w_do_push;
    logic w_do_pop;

    // Extra pointer MSB distinguishes a full wrap from an empty FIFO.
    assign w_empty   = (r_wr_ptr == r_rd_ptr);
    assign w_full    = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                       (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign w_do_pop  = i_pop & ~w_empty;
    assign w_do_push = i_push & (~w_full | w_do_pop);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
        end
    end

    // Storage needs no reset: stale entries are hidden by the pointers.
    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr[AW-1:0]] <= i_data;
        end
    end

    assign o_data  = w_empty ? '0 : r_mem[r_rd_ptr[AW-1:0]];
    assign o_full  = w_full;
    assign o_empty = w_empty;

endmodule

// File: rtl/nios2_oci_dct_unpacker.sv
// Unpacks DCT trace frames LSB-slot-first into a slot stream and sequences test end.
// Define OCI_DCT_STATS_EN to add the frame_cnt / slot_cnt statistics outputs.
module nios2_oci_dct_unpacker
    import nios2_oci_dct_pkg::*;
#(
    parameter int SLOT_W     = 2,
    parameter int SLOTS      = 15,
    parameter int CNT_W      = 4,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    dct_valid,
    output logic                    dct_ready,
    input  logic [SLOT_W*SLOTS-1:0] dct_buffer,
    input  logic [CNT_W-1:0]        dct_count,
    input  logic                    test_ending,
    output logic                    slot_valid,
    input  logic                    slot_ready,
    output logic [SLOT_W-1:0]       slot_data,
    output logic                    count_err,
    output logic                    test_has_ended
`ifdef OCI_DCT_STATS_EN
    ,
    output logic [31:0]             frame_cnt,
    output logic [31:0]             slot_cnt
`endif
);

    localparam logic [CNT_W-1:0] SLOTS_C = CNT_W'(SLOTS);
    localparam logic [CNT_W-1:0] ONE_C   = CNT_W'(1);

    dct_state_e                r_state;
    logic [SLOT_W*SLOTS-1:0]   r_shift;
    logic [CNT_W-1:0]          r_remain;
    logic                      r_end_latch;
    logic                      r_dct_ready;
    logic                      r_count_err;
    logic                      r_test_has_ended;

    logic                      w_accept;
    logic                      w_end_req;
    logic                      w_cnt_over;
    logic [CNT_W-1:0]          w_cnt_clamp;
    logic                      w_fifo_full;
    logic                      w_fifo_empty;
    logic                      w_push_ok;
    logic [SLOT_W-1:0]         w_fifo_data;

    assign w_accept    = dct_valid & r_dct_ready;
    assign w_end_req   = r_end_latch | test_ending;
    assign w_cnt_over  = (dct_count > SLOTS_C);
    assign w_cnt_clamp = w_cnt_over ? SLOTS_C : dct_count;

    // A full FIFO still takes a slot when the consumer pops in the same cycle.
    assign w_push_ok = (r_state == UNPACK) &
                       (~w_fifo_full | (slot_ready & ~w_fifo_empty));

    nios2_oci_dct_fifo #(
        .SLOT_W     (SLOT_W),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (reset_n),
        .i_push  (w_push_ok),
        .i_data  (r_shift[SLOT_W-1:0]),
        .i_pop   (slot_ready),
        .o_data  (w_fifo_data),
        .o_full  (w_fifo_full),
        .o_empty (w_fifo_empty)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state          <= IDLE;
            r_shift          <= '0;
            r_remain         <= '0;
            r_end_latch      <= 1'b0;
            r_dct_ready      <= 1'b0;
            r_count_err      <= 1'b0;
            r_test_has_ended <= 1'b0;
        end else begin
            if (test_ending) begin
                r_end_latch <= 1'b1;
            end
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_shift  <= dct_buffer;
                        r_remain <= w_cnt_clamp;
                        if (w_cnt_over) begin
                            r_count_err <= 1'b1;
                        end
                    end
                    // An accepted frame is always unpacked before the end request is honoured.
                    if (w_accept && (w_cnt_clamp != '0)) begin
                        r_state     <= UNPACK;
                        r_dct_ready <= 1'b0;
                    end else if (w_end_req) begin
                        r_state     <= DRAIN;
                        r_dct_ready <= 1'b0;
                    end else begin
                        r_dct_ready <= 1'b1;
                    end
                end
                UNPACK: begin
                    r_dct_ready <= 1'b0;
                    if (w_push_ok) begin
                        r_shift  <= r_shift >> SLOT_W;
                        r_remain <= r_remain - 1'b1;
                        if (r_remain == ONE_C) begin
                            if (w_end_req) begin
                                r_state <= DRAIN;
                            end else begin
                                r_state     <= IDLE;
                                r_dct_ready <= 1'b1;
                            end
                        end
                    end
                end
                DRAIN: begin
                    r_dct_ready <= 1'b0;
                    if (w_fifo_empty) begin
                        r_state          <= ENDED;
                        r_test_has_ended <= 1'b1;
                    end
                end
                ENDED: begin
                    r_dct_ready <= 1'b0;
                end
                default: begin
                    r_state     <= IDLE;
                    r_dct_ready <= 1'b0;
                end
            endcase
        end
    end

`ifdef OCI_DCT_STATS_EN
    logic [31:0] r_frame_cnt;
    logic [31:0] r_slot_cnt;

    // Counters saturate and stop once the end of test has been reported.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_frame_cnt <= '0;
            r_slot_cnt  <= '0;
        end else if (!r_test_has_ended) begin
            if (w_accept && (r_frame_cnt != '1)) begin
                r_frame_cnt <= r_frame_cnt + 32'd1;
            end
            if (slot_ready && !w_fifo_empty && (r_slot_cnt != '1)) begin
                r_slot_cnt <= r_slot_cnt + 32'd1;
            end
        end
    end

    assign frame_cnt = r_frame_cnt;
    assign slot_cnt  = r_slot_cnt;
`endif

    assign dct_ready      = r_dct_ready;
    assign slot_valid     = ~w_fifo_empty;
    assign slot_data      = w_fifo_data;
    assign count_err      = r_count_err;
    assign test_has_ended = r_test_has_ended;

endmodule

// File: tb/tb_nios2_oci_dct_unpacker.sv
// Randomised self-checking bench: three unpacker instances (default, shallow FIFO,
// 14-slot frames) checked against a per-instance queue model of the slot stream.
module tb_nios2_oci_dct_unpacker;

    localparam int NI = 3;
    localparam int QN = 1024;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                  reset_n;
    logic [NI-1:0]         dct_valid;
    logic [NI-1:0]         dct_ready;
    logic [29:0]           dct_buffer [NI];
    logic [3:0]            dct_count  [NI];
    logic [NI-1:0]         test_ending;
    logic [NI-1:0]         slot_valid;
    logic [NI-1:0]         slot_ready;
    logic [NI-1:0][1:0]    slot_data;
    logic [NI-1:0]         count_err;
    logic [NI-1:0]         test_has_ended;
`ifdef OCI_DCT_STATS_EN
    logic [NI-1:0][31:0]   frame_cnt;
    logic [NI-1:0][31:0]   slot_cnt;
`endif

    generate
        for (genvar gi = 0; gi < NI; gi++) begin : g_dut
            localparam int S = (gi == 2) ? 14 : 15;
            localparam int D = (gi == 1) ? 4 : 16;
            nios2_oci_dct_unpacker #(
                .SLOT_W     (2),
                .SLOTS      (S),
                .CNT_W      (4),
                .FIFO_DEPTH (D)
            ) u_dut (
                .clk            (clk),
                .reset_n        (reset_n),
                .dct_valid      (dct_valid[gi]),
                .dct_ready      (dct_ready[gi]),
                .dct_buffer     (dct_buffer[gi][2*S-1:0]),
                .dct_count      (dct_count[gi]),
                .test_ending    (test_ending[gi]),
                .slot_valid     (slot_valid[gi]),
                .slot_ready     (slot_ready[gi]),
                .slot_data      (slot_data[gi]),
                .count_err      (count_err[gi]),
                .test_has_ended (test_has_ended[gi])
`ifdef OCI_DCT_STATS_EN
                ,
                .frame_cnt      (frame_cnt[gi]),
                .slot_cnt       (slot_cnt[gi])
`endif
            );
        end
    endgenerate

    // Reference model: expected slot queue per instance plus sticky flags.
    logic [1:0] exp_mem [NI][QN];
    int         wr_i    [NI];
    int         rd_i    [NI];
    int         acc_cnt [NI];
    int         pop_cnt [NI];
    logic       exp_err [NI];

    int err_cnt = 0;
    int chk_cnt = 0;

    function automatic int slots_of(input int i);
        return (i == 2) ? 14 : 15;
    endfunction

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        chk_cnt++;
        if (obs !== exp_v) begin
            err_cnt++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    // Called at a negedge with inputs set: score the handshakes of the coming edge.
    task automatic tick();
        for (int i = 0; i < NI; i++) begin
            if (!slot_valid[i]) begin
                check_val($sformatf("idle_data_zero[%0d]", i), 32'(slot_data[i]), 32'd0);
            end
            if (dct_valid[i] && dct_ready[i]) begin
                int n;
                n = (int'(dct_count[i]) > slots_of(i)) ? slots_of(i) : int'(dct_count[i]);
                if (int'(dct_count[i]) > slots_of(i)) begin
                    exp_err[i] = 1'b1;
                end
                for (int k = 0; k < n; k++) begin
                    exp_mem[i][wr_i[i] % QN] = dct_buffer[i][2*k +: 2];
                    wr_i[i]++;
                end
                acc_cnt[i]++;
            end
            if (slot_valid[i] && slot_ready[i]) begin
                check_val($sformatf("pop_expected[%0d]", i), 32'(wr_i[i] != rd_i[i]), 32'd1);
                if (wr_i[i] != rd_i[i]) begin
                    check_val($sformatf("slot_data[%0d]", i), 32'(slot_data[i]),
                              32'(exp_mem[i][rd_i[i] % QN]));
                    rd_i[i]++;
                end
                pop_cnt[i]++;
            end
        end
        @(negedge clk);
    endtask

    task automatic clear_inputs();
        for (int i = 0; i < NI; i++) begin
            dct_valid[i]   = 1'b0;
            dct_buffer[i]  = '0;
            dct_count[i]   = '0;
            test_ending[i] = 1'b0;
            slot_ready[i]  = 1'b0;
        end
    endtask

    // Called at a negedge: reset drops between edges and must clear at once.
    task automatic do_reset();
        #2 reset_n = 1'b0;
        #1;
        clear_inputs();
        for (int i = 0; i < NI; i++) begin
            check_val($sformatf("rst_ready[%0d]", i), 32'(dct_ready[i]), 32'd0);
            check_val($sformatf("rst_valid[%0d]", i), 32'(slot_valid[i]), 32'd0);
            check_val($sformatf("rst_data[%0d]", i), 32'(slot_data[i]), 32'd0);
            check_val($sformatf("rst_cerr[%0d]", i), 32'(count_err[i]), 32'd0);
            check_val($sformatf("rst_ended[%0d]", i), 32'(test_has_ended[i]), 32'd0);
            wr_i[i] = 0;
            rd_i[i] = 0;
            acc_cnt[i] = 0;
            pop_cnt[i] = 0;
            exp_err[i] = 1'b0;
        end
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        for (int i = 0; i < NI; i++) begin
            check_val($sformatf("ready_release_cycle[%0d]", i), 32'(dct_ready[i]), 32'd0);
        end
        tick();
        for (int i = 0; i < NI; i++) begin
            check_val($sformatf("ready_after_release[%0d]", i), 32'(dct_ready[i]), 32'd1);
        end
    endtask

    task automatic send_frame(input int i, input logic [29:0] buf_v, input logic [3:0] cnt, input int budget);
        int a0;
        int g;
        a0 = acc_cnt[i];
        g = 0;
        dct_buffer[i] = buf_v;
        dct_count[i]  = cnt;
        dct_valid[i]  = 1'b1;
        while (acc_cnt[i] == a0 && g < budget) begin
            tick();
            g++;
        end
        check_val($sformatf("frame_accept[%0d]", i), 32'(acc_cnt[i] - a0), 32'd1);
        dct_valid[i] = 1'b0;
    endtask

    task automatic drain(input int i, input int budget);
        int c;
        c = 0;
        slot_ready[i] = 1'b1;
        while ((wr_i[i] != rd_i[i] || slot_valid[i]) && c < budget) begin
            tick();
            c++;
        end
        check_val($sformatf("drain_done[%0d]", i),
                  32'((wr_i[i] == rd_i[i]) && !slot_valid[i]), 32'd1);
    endtask

    task automatic check_stats(input int i);
`ifdef OCI_DCT_STATS_EN
        check_val($sformatf("frame_cnt[%0d]", i), frame_cnt[i], 32'(acc_cnt[i]));
        check_val($sformatf("slot_cnt[%0d]", i), slot_cnt[i], 32'(pop_cnt[i]));
`else
        check_val($sformatf("queue_balance[%0d]", i), 32'(wr_i[i] - rd_i[i]), 32'd0);
`endif
    endtask

    task automatic random_phase(input int i, input int nframes);
        int a0;
        int g;
        for (int f = 0; f < nframes; f++) begin
            dct_buffer[i] = 30'($urandom);
            dct_count[i]  = 4'($urandom_range(0, 15));
            dct_valid[i]  = 1'b1;
            a0 = acc_cnt[i];
            g = 0;
            while (acc_cnt[i] == a0 && g < 200) begin
                slot_ready[i] = ($urandom_range(0, 3) != 0);
                tick();
                g++;
            end
            check_val($sformatf("rand_accept[%0d]", i), 32'(acc_cnt[i] - a0), 32'd1);
            dct_valid[i] = 1'b0;
            repeat ($urandom_range(0, 3)) begin
                slot_ready[i] = 1'($urandom_range(0, 1));
                tick();
            end
        end
        drain(i, 400);
        check_val($sformatf("rand_count_err[%0d]", i), 32'(count_err[i]), 32'(exp_err[i]));
        check_stats(i);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int p0;
        int a0;
        int c;
        int last_v;
        logic seen_ready;
        logic [29:0] b;

        reset_n = 1'b1;
        clear_inputs();
        for (int i = 0; i < NI; i++) begin
            wr_i[i] = 0; rd_i[i] = 0; acc_cnt[i] = 0; pop_cnt[i] = 0; exp_err[i] = 1'b0;
        end
        @(negedge clk);
        do_reset();

        // Full 15-slot frame of 2'b10, streamed with no backpressure.
        slot_ready[0] = 1'b1;
        p0 = pop_cnt[0];
        send_frame(0, 30'h2AAAAAAA, 4'd15, 10);
        check_val("first_slot_latency", 32'(slot_valid[0]), 32'd0);
        tick();
        for (int k = 0; k < 15; k++) begin
            check_val("stream_valid", 32'(slot_valid[0]), 32'd1);
            check_val("stream_ready", 32'(dct_ready[0]), 32'(k == 14));
            tick();
        end
        check_val("stream_end", 32'(slot_valid[0]), 32'd0);
        check_val("stream_pops", 32'(pop_cnt[0] - p0), 32'd15);
        check_val("stream_cerr", 32'(count_err[0]), 32'd0);

        // Three slots 1,2,3 held in the FIFO under backpressure.
        slot_ready[0] = 1'b0;
        p0 = pop_cnt[0];
        b = 30'($urandom);
        b[5:0] = 6'b111001;
        send_frame(0, b, 4'd3, 10);
        repeat (5) tick();
        check_val("hold_ready", 32'(dct_ready[0]), 32'd1);
        for (int k = 0; k < 3; k++) begin
            check_val("hold_valid", 32'(slot_valid[0]), 32'd1);
            check_val("hold_data", 32'(slot_data[0]), 32'd1);
            tick();
        end
        drain(0, 20);
        check_val("hold_pops", 32'(pop_cnt[0] - p0), 32'd3);

        random_phase(0, 60);

        // Shallow FIFO: unpacker stalls, second frame waits.
        slot_ready[1] = 1'b0;
        p0 = pop_cnt[1];
        send_frame(1, 30'($urandom), 4'd15, 10);
        dct_buffer[1] = 30'($urandom);
        dct_count[1]  = 4'd15;
        dct_valid[1]  = 1'b1;
        a0 = acc_cnt[1];
        seen_ready = 1'b0;
        repeat (25) begin
            seen_ready = seen_ready | dct_ready[1];
            tick();
        end
        check_val("stall_ready", 32'(seen_ready), 32'd0);
        check_val("stall_accepts", 32'(acc_cnt[1] - a0), 32'd0);
        check_val("stall_valid", 32'(slot_valid[1]), 32'd1);
        slot_ready[1] = 1'b1;
        c = 0;
        while (acc_cnt[1] == a0 && c < 60) begin
            tick();
            c++;
        end
        check_val("stall_second_accept", 32'(acc_cnt[1] - a0), 32'd1);
        dct_valid[1] = 1'b0;
        drain(1, 80);
        check_val("stall_pops", 32'(pop_cnt[1] - p0), 32'd30);

        random_phase(1, 60);

        // 14-slot build: over-long count clamps and flags; zero count emits nothing.
        slot_ready[2] = 1'b1;
        p0 = pop_cnt[2];
        send_frame(2, 30'($urandom), 4'hF, 10);
        drain(2, 40);
        check_val("clamp_pops", 32'(pop_cnt[2] - p0), 32'd14);
        check_val("clamp_cerr", 32'(count_err[2]), 32'd1);
        p0 = pop_cnt[2];
        send_frame(2, 30'($urandom), 4'd0, 10);
        check_val("zero_ready_back", 32'(dct_ready[2]), 32'd1);
        repeat (3) tick();
        check_val("zero_no_slot", 32'(slot_valid[2]), 32'd0);
        check_val("zero_pops", 32'(pop_cnt[2] - p0), 32'd0);
        check_val("cerr_sticky", 32'(count_err[2]), 32'd1);

        random_phase(2, 60);

        // End-of-test request in the middle of an 8-slot frame.
        slot_ready[0] = 1'b1;
        p0 = pop_cnt[0];
        a0 = acc_cnt[0];
        send_frame(0, 30'($urandom), 4'd8, 10);
        repeat (3) tick();
        test_ending[0] = 1'b1;
        tick();
        test_ending[0] = 1'b0;
        dct_buffer[0] = 30'($urandom);
        dct_count[0]  = 4'd5;
        dct_valid[0]  = 1'b1;
        c = 0;
        last_v = -1;
        while (!test_has_ended[0] && c < 60) begin
            if (slot_valid[0]) last_v = c;
            tick();
            c++;
        end
        check_val("ended_seen", 32'(test_has_ended[0]), 32'd1);
        check_val("ended_timing", 32'(c), 32'(last_v + 2));
        check_val("end_pops", 32'(pop_cnt[0] - p0), 32'd8);
        repeat (10) tick();
        check_val("end_no_accept", 32'(acc_cnt[0] - a0), 32'd1);
        check_val("end_ready_low", 32'(dct_ready[0]), 32'd0);
        check_val("end_sticky", 32'(test_has_ended[0]), 32'd1);
        check_stats(0);
        dct_valid[0] = 1'b0;

        // Asynchronous reset in the middle of a frame, then a fresh 2-slot frame.
        slot_ready[0] = 1'b0;
        do_reset();
        send_frame(0, 30'($urandom), 4'd15, 10);
        repeat (4) tick();
        do_reset();
        check_val("reset_cerr_c", 32'(count_err[2]), 32'd0);
        slot_ready[0] = 1'b1;
        send_frame(0, 30'($urandom), 4'd2, 10);
        drain(0, 20);
        check_val("post_reset_pops", 32'(pop_cnt[0]), 32'd2);
`ifdef OCI_DCT_STATS_EN
        check_val("post_reset_frame_cnt", frame_cnt[0], 32'd1);
        check_val("post_reset_slot_cnt", slot_cnt[0], 32'd2);
`endif

        $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
        $finish;
    end

endmodule
